// File: rtl/mmu_tx_pkg.sv
// ---------------------------------------------------------------------------
// mmu_tx_pkg
// Shared definitions for the mmu_tx read-command path: default word geometry
// of the RQ FIFO word and the state encoding of the RQ write-port arbiter.
// ---------------------------------------------------------------------------
package mmu_tx_pkg;

    localparam int MMU_TX_DW      = 288;  // RQ FIFO word width
    localparam int MMU_TX_EOP_POS = 262;  // end-of-packet flag position
    localparam int MMU_TX_ERR_POS = 261;  // error flag position
    localparam int MMU_TX_CNT_W   = 16;   // dfx counter width

    // Encoding is visible on arb_sta, so the values are fixed.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mmu_tx_rq_arb.sv
// ---------------------------------------------------------------------------
// mmu_tx_rq_arb
// Packet-atomic 2:1 arbiter for the shared RQ FIFO write port.  Port 0 carries
// BD-read commands, port 1 packet-read commands.  Both sources are show-ahead
// FIFOs.  Once a port is granted, its words are forwarded until the word with
// EOP is popped; the other port is never popped in between.  Popped words are
// registered and appear on rq_tx_wr/rq_tx_wdata one cycle after the pop.
//
// Build option:
//   MMU_TX_ARB_WRR_EN  defined   -> weighted round robin using reg_arb_weight*
//                      undefined -> strict alternating round robin,
//                                   reg_arb_weight* unused
//
// Ports:
//   clk_sys, rst                         clock, synchronous active-high reset
//   src{0,1}_fifo_emp/_rdata/_rd         source FIFO empty, head word, pop
//   rq_tx_wr/_wdata                      RQ FIFO write strobe and word
//   rq_tx_ff                             RQ FIFO almost-full (stalls pops)
//   reg_arb_weight{0,1}                  per-port packet weight (WRR only)
//   arb_sta                              FSM state
//   arb_pkt_cnt{0,1}, arb_err_cnt        wrapping packet / error-word counts
// ---------------------------------------------------------------------------
module mmu_tx_rq_arb
    import mmu_tx_pkg::*;
#(
    parameter int DW      = MMU_TX_DW,
    parameter int EOP_POS = MMU_TX_EOP_POS,
    parameter int ERR_POS = MMU_TX_ERR_POS,
    parameter int CNT_W   = MMU_TX_CNT_W
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             src0_fifo_emp,
    input  logic [DW-1:0]    src0_fifo_rdata,
    output logic             src0_fifo_rd,
    input  logic             src1_fifo_emp,
    input  logic [DW-1:0]    src1_fifo_rdata,
    output logic             src1_fifo_rd,
    output logic             rq_tx_wr,
    output logic [DW-1:0]    rq_tx_wdata,
    input  logic             rq_tx_ff,
    input  logic [3:0]       reg_arb_weight0,
    input  logic [3:0]       reg_arb_weight1,
    output logic [1:0]       arb_sta,
    output logic [CNT_W-1:0] arb_pkt_cnt0,
    output logic [CNT_W-1:0] arb_pkt_cnt1,
    output logic [CNT_W-1:0] arb_err_cnt
);

    arb_state_e       state_q;
    logic             wr_q;
    logic [DW-1:0]    wdata_q;
    logic [CNT_W-1:0] pkt_cnt0_q;
    logic [CNT_W-1:0] pkt_cnt1_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             pop;
    logic             pop_sel1;
    logic [DW-1:0]    pop_word;
    logic             pop_eop;
    logic             pop_err;
    logic             pick_vld;
    logic             pick1;
    logic             prefer1;

    // Pops are combinational so the show-ahead head word is consumed in the
    // same cycle it is seen; a stalled grant simply drops the pop.
    assign src0_fifo_rd = (state_q == ARB_GNT0) & ~src0_fifo_emp & ~rq_tx_ff;
    assign src1_fifo_rd = (state_q == ARB_GNT1) & ~src1_fifo_emp & ~rq_tx_ff;

    assign pop      = src0_fifo_rd | src1_fifo_rd;
    assign pop_sel1 = src1_fifo_rd;
    assign pop_word = pop_sel1 ? src1_fifo_rdata : src0_fifo_rdata;
    assign pop_eop  = pop_word[EOP_POS];
    assign pop_err  = pop_word[ERR_POS];

    // With a single requester it wins outright; with two, the fairness
    // pointer decides.
    assign pick_vld = ~src0_fifo_emp | ~src1_fifo_emp;
    assign pick1    = (~src0_fifo_emp & ~src1_fifo_emp) ? prefer1 : src0_fifo_emp;

`ifdef MMU_TX_ARB_WRR_EN
    // last_q: port that ended the most recent packet; cons_q: how many
    // packets in a row it has finished.  The owner keeps priority until its
    // weight is used up, then priority moves and the count restarts at 1.
    logic       last_q;
    logic [3:0] cons_q;
    logic [3:0] weight_raw;
    logic [3:0] weight_eff;

    assign weight_raw = last_q ? reg_arb_weight1 : reg_arb_weight0;
    assign weight_eff = (weight_raw == 4'd0) ? 4'd1 : weight_raw;
    assign prefer1    = (cons_q < weight_eff) ? last_q : ~last_q;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            last_q <= 1'b0;
            cons_q <= 4'd0;
        end else if (pop & pop_eop) begin
            if (pop_sel1 == last_q) begin
                if (cons_q != 4'hF) begin
                    cons_q <= cons_q + 4'd1;
                end
            end else begin
                last_q <= pop_sel1;
                cons_q <= 4'd1;
            end
        end
    end
`else
    // Priority flips to the other port after every packet.
    logic rr_q;
    logic unused_weights;

    assign prefer1        = rr_q;
    assign unused_weights = ^{reg_arb_weight0, reg_arb_weight1};

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else if (pop & pop_eop) begin
            rr_q <= ~pop_sel1;
        end
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            wr_q <= pop;
            if (pop) begin
                wdata_q <= pop_word;
            end
            if (pop & pop_err) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            case (state_q)
                // Decision cycle: no pop is issued here.
                ARB_IDLE: begin
                    if (pick_vld) begin
                        state_q <= pick1 ? ARB_GNT1 : ARB_GNT0;
                    end
                end
                ARB_GNT0: begin
                    if (src0_fifo_rd & pop_eop) begin
                        state_q    <= ARB_IDLE;
                        pkt_cnt0_q <= pkt_cnt0_q + CNT_W'(1);
                    end
                end
                ARB_GNT1: begin
                    if (src1_fifo_rd & pop_eop) begin
                        state_q    <= ARB_IDLE;
                        pkt_cnt1_q <= pkt_cnt1_q + CNT_W'(1);
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign rq_tx_wr     = wr_q;
    assign rq_tx_wdata  = wdata_q;
    assign arb_sta      = state_q;
    assign arb_pkt_cnt0 = pkt_cnt0_q;
    assign arb_pkt_cnt1 = pkt_cnt1_q;
    assign arb_err_cnt  = err_cnt_q;

endmodule
